// File: rtl/mac_pkg.sv
// Shared constants for the MAC output stage: field widths, result layout
// and per-block transistor counts reported to the controller.
package mac_pkg;

    localparam int EXP_W   = 6;
    localparam int MAN_W   = 9;
    localparam int NORM_W  = 11;
    localparam int DIFF_W  = 5;
    localparam int EXP_MAX = 63;
    localparam int RES_W   = 1 + EXP_W + MAN_W;
    localparam int TAG_W   = 5;

    // Result field offsets: {sgn, exp, man}
    localparam int RES_SGN_POS = RES_W - 1;
    localparam int RES_EXP_LSB = MAN_W;
    localparam int RES_MAN_LSB = 0;

    // Exponent arithmetic is carried in 8-bit two's complement so that
    // both the overflow (>63) and the underflow (<1) cases are visible.
    localparam int E_W = 8;

    // Transistor budgets of the individual blocks.
    localparam int TR_EXP_ADD   = 224;   // 8-bit exponent adder
    localparam int TR_PACK_BASE = 420;   // saturate/flush muxing and packing
    localparam int TR_RND_INC   = 108;   // 9-bit rounding incrementer

    function automatic logic [RES_W-1:0] pack_fields(input logic s,
                                                     input logic [EXP_W-1:0] e,
                                                     input logic [MAN_W-1:0] m);
        logic [RES_W-1:0] r;
        r = '0;
        r[RES_SGN_POS] = s;
        r[RES_EXP_LSB +: EXP_W] = e;
        r[RES_MAN_LSB +: MAN_W] = m;
        return r;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round, exponent reconstruction, saturate/flush and pack.
// Build option: MAC_STG5_RNE_EN selects round-to-nearest-even; without it
// the mantissa is truncated and no incrementer exists.
module fp_round_pack
    import mac_pkg::*;
(
    input  logic [10:0] i_norm_sum,
    input  logic [4:0]  i_exp_diff,
    input  logic        i_exp_carry,
    input  logic        i_sgn,
    input  logic [5:0]  i_max_exp,
    output logic [15:0] o_result,
    output logic        o_ovf_evt,
    output logic        o_unf_evt,
    output logic [31:0] o_tr_num
);

    logic [MAN_W-1:0] man_rnd;
    logic             rnd_carry;
    logic [E_W-1:0]   exp_sum;

`ifdef MAC_STG5_RNE_EN
    // Round to nearest even with a single guard bit: only odd mantissas round up.
    always_comb begin
        logic round_up;
        round_up  = i_norm_sum[0] & i_norm_sum[1];
        {rnd_carry, man_rnd} = {1'b0, i_norm_sum[MAN_W:1]} + {{MAN_W{1'b0}}, round_up};
    end

    assign o_tr_num = 32'(TR_PACK_BASE + TR_RND_INC);
`else
    // Truncation: guard bit is dropped.
    always_comb begin
        rnd_carry = 1'b0;
        man_rnd   = i_norm_sum[MAN_W:1];
    end

    assign o_tr_num = 32'(TR_PACK_BASE);
`endif

    // Exponent reconstruction, then zero / saturate / flush selection.
    always_comb begin
        exp_sum = {2'b00, i_max_exp}
                + {{(E_W-DIFF_W){i_exp_diff[DIFF_W-1]}}, i_exp_diff}
                + {{(E_W-1){1'b0}}, i_exp_carry}
                + {{(E_W-1){1'b0}}, rnd_carry};

        o_ovf_evt = 1'b0;
        o_unf_evt = 1'b0;
        o_result  = pack_fields(i_sgn, exp_sum[EXP_W-1:0], man_rnd);

        if (i_norm_sum == '0) begin
            o_result = pack_fields(i_sgn, '0, '0);
        end else if ($signed(exp_sum) > $signed(E_W'(EXP_MAX))) begin
            o_result  = pack_fields(i_sgn, '1, '1);
            o_ovf_evt = 1'b1;
        end else if ($signed(exp_sum) < $signed(E_W'(1))) begin
            o_result  = pack_fields(i_sgn, '0, '0);
            o_unf_evt = 1'b1;
        end
    end

endmodule

// File: rtl/mac_stg5_pack.sv
// Final MAC stage: two-stage register pipeline around fp_round_pack with
// sticky overflow/underflow flags and a produced-result counter.
// Build option: MAC_STG5_RNE_EN (round-to-nearest-even, else truncation).
module mac_stg5_pack
    import mac_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int NUM_W = 51
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_inhibit,
    input  logic [10:0]      i_norm_sum,
    input  logic [4:0]       i_exp_diff,
    input  logic             i_exp_carry,
    input  logic             i_sgn,
    input  logic [5:0]       i_max_exp,
    input  logic [4:0]       i_Q_frac,
    input  logic             i_clr,
    output logic             o_valid,
    output logic [15:0]      o_result,
    output logic [4:0]       o_Q_frac,
    output logic             o_ovf,
    output logic             o_unf,
    output logic [CNT_W-1:0] o_out_cnt,
    output logic [NUM_W-1:0] o_transistor_num
);

    logic              a_valid_q,  a_valid_d;
    logic [10:0]       a_norm_q,   a_norm_d;
    logic [4:0]        a_diff_q,   a_diff_d;
    logic              a_carry_q,  a_carry_d;
    logic              a_sgn_q,    a_sgn_d;
    logic [5:0]        a_mexp_q,   a_mexp_d;
    logic [4:0]        a_qfrac_q,  a_qfrac_d;

    logic              b_valid_q,  b_valid_d;
    logic [15:0]       b_result_q, b_result_d;
    logic [4:0]        b_qfrac_q,  b_qfrac_d;
    logic              ovf_q,      ovf_d;
    logic              unf_q,      unf_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic [15:0]       pk_result;
    logic              pk_ovf_evt;
    logic              pk_unf_evt;
    logic [31:0]       pk_tr_num;
    logic              load_b;

    fp_round_pack u_round_pack (
        .i_norm_sum  (a_norm_q),
        .i_exp_diff  (a_diff_q),
        .i_exp_carry (a_carry_q),
        .i_sgn       (a_sgn_q),
        .i_max_exp   (a_mexp_q),
        .o_result    (pk_result),
        .o_ovf_evt   (pk_ovf_evt),
        .o_unf_evt   (pk_unf_evt),
        .o_tr_num    (pk_tr_num)
    );

    assign load_b = a_valid_q & ~i_inhibit;

    // Next-state for both pipeline stages, flags and counter.
    always_comb begin
        a_valid_d  = a_valid_q;
        a_norm_d   = a_norm_q;
        a_diff_d   = a_diff_q;
        a_carry_d  = a_carry_q;
        a_sgn_d    = a_sgn_q;
        a_mexp_d   = a_mexp_q;
        a_qfrac_d  = a_qfrac_q;
        b_valid_d  = b_valid_q;
        b_result_d = b_result_q;
        b_qfrac_d  = b_qfrac_q;

        if (!i_inhibit) begin
            a_valid_d  = i_valid;
            a_norm_d   = i_norm_sum;
            a_diff_d   = i_exp_diff;
            a_carry_d  = i_exp_carry;
            a_sgn_d    = i_sgn;
            a_mexp_d   = i_max_exp;
            a_qfrac_d  = i_Q_frac;
            b_valid_d  = a_valid_q;
            b_result_d = pk_result;
            b_qfrac_d  = a_qfrac_q;
        end

        // Clear acts even while stalled; a simultaneous set event wins.
        ovf_d = (i_clr ? 1'b0 : ovf_q) | (load_b & pk_ovf_evt);
        unf_d = (i_clr ? 1'b0 : unf_q) | (load_b & pk_unf_evt);
        cnt_d = (i_clr ? '0 : cnt_q) + {{(CNT_W-1){1'b0}}, load_b};
    end

    // Pipeline, flag and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_valid_q  <= 1'b0;
            a_norm_q   <= '0;
            a_diff_q   <= '0;
            a_carry_q  <= 1'b0;
            a_sgn_q    <= 1'b0;
            a_mexp_q   <= '0;
            a_qfrac_q  <= '0;
            b_valid_q  <= 1'b0;
            b_result_q <= '0;
            b_qfrac_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_norm_q   <= a_norm_d;
            a_diff_q   <= a_diff_d;
            a_carry_q  <= a_carry_d;
            a_sgn_q    <= a_sgn_d;
            a_mexp_q   <= a_mexp_d;
            a_qfrac_q  <= a_qfrac_d;
            b_valid_q  <= b_valid_d;
            b_result_q <= b_result_d;
            b_qfrac_q  <= b_qfrac_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_valid          = b_valid_q;
    assign o_result         = b_result_q;
    assign o_Q_frac         = b_qfrac_q;
    assign o_ovf            = ovf_q;
    assign o_unf            = unf_q;
    assign o_out_cnt        = cnt_q;
    assign o_transistor_num = NUM_W'(TR_EXP_ADD) + NUM_W'(pk_tr_num);

endmodule

// File: tb/tb_mac_stg5_pack.sv
// Directed bench for mac_stg5_pack: vector table plus hand-written
// sequences for sticky flags, clear priority, stall and reset.
module tb_mac_stg5_pack;

    localparam int CNT_W = 16;
    localparam int NUM_W = 51;

    logic             clk;
    logic             rst_n;
    logic             i_valid;
    logic             i_inhibit;
    logic [10:0]      i_norm_sum;
    logic [4:0]       i_exp_diff;
    logic             i_exp_carry;
    logic             i_sgn;
    logic [5:0]       i_max_exp;
    logic [4:0]       i_Q_frac;
    logic             i_clr;
    logic             o_valid;
    logic [15:0]      o_result;
    logic [4:0]       o_Q_frac;
    logic             o_ovf;
    logic             o_unf;
    logic [CNT_W-1:0] o_out_cnt;
    logic [NUM_W-1:0] o_transistor_num;

    int errors = 0;
    int checks = 0;

    mac_stg5_pack #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_valid          (i_valid),
        .i_inhibit        (i_inhibit),
        .i_norm_sum       (i_norm_sum),
        .i_exp_diff       (i_exp_diff),
        .i_exp_carry      (i_exp_carry),
        .i_sgn            (i_sgn),
        .i_max_exp        (i_max_exp),
        .i_Q_frac         (i_Q_frac),
        .i_clr            (i_clr),
        .o_valid          (o_valid),
        .o_result         (o_result),
        .o_Q_frac         (o_Q_frac),
        .o_ovf            (o_ovf),
        .o_unf            (o_unf),
        .o_out_cnt        (o_out_cnt),
        .o_transistor_num (o_transistor_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] norm;
        logic [4:0]  diff;
        logic        carry;
        logic        sgn;
        logic [5:0]  mexp;
        logic [4:0]  q;
        logic [15:0] res;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic vld);
        i_valid     = vld;
        i_norm_sum  = v.norm;
        i_exp_diff  = v.diff;
        i_exp_carry = v.carry;
        i_sgn       = v.sgn;
        i_max_exp   = v.mexp;
        i_Q_frac    = v.q;
    endtask

    // One isolated transaction; optionally clears flags/counter on the capture edge.
    task automatic run_vec(input vec_t v, input logic do_clr, input string name);
        drive(v, 1'b1);
        i_clr = do_clr;
        tick();
        i_valid = 1'b0;
        i_clr   = 1'b0;
        chk({name, "_lat"}, 64'(o_valid), 64'(0));
        tick();
        chk({name, "_vld"}, 64'(o_valid), 64'(1));
        chk({name, "_res"}, 64'(o_result), 64'(v.res));
        chk({name, "_q"},   64'(o_Q_frac), 64'(v.q));
        if (do_clr) begin
            chk({name, "_ovf"}, 64'(o_ovf), 64'(v.ovf));
            chk({name, "_unf"}, 64'(o_unf), 64'(v.unf));
            chk({name, "_cnt"}, 64'(o_out_cnt), 64'(1));
        end
        tick();
        chk({name, "_drop"}, 64'(o_valid), 64'(0));
    endtask

    initial begin
        vec_t clean;
        vec_t sv[6];
        logic [15:0] prev_res;
        logic        prev_vld;
        logic [CNT_W-1:0] prev_cnt;
        logic [NUM_W-1:0] tr_exp;
        int idx;
        int outn;
        logic inh;

        //             norm     diff   c  s  mexp q      res       ovf unf
        tbl[0]  = '{11'h400, 5'h00, 0, 0, 6'd30, 5'd1,  16'h3C00, 0, 0};
`ifdef MAC_STG5_RNE_EN
        tbl[1]  = '{11'h7FF, 5'h00, 0, 0, 6'd30, 5'd2,  16'h3E00, 0, 0};
        tbl[5]  = '{11'h5FF, 5'h00, 0, 0, 6'd63, 5'd6,  16'h7F00, 0, 0};
        tbl[10] = '{11'h7FF, 5'h00, 0, 0, 6'd63, 5'd11, 16'h7FFF, 1, 0};
        tr_exp  = NUM_W'(752);
`else
        tbl[1]  = '{11'h7FF, 5'h00, 0, 0, 6'd30, 5'd2,  16'h3DFF, 0, 0};
        tbl[5]  = '{11'h5FF, 5'h00, 0, 0, 6'd63, 5'd6,  16'h7EFF, 0, 0};
        tbl[10] = '{11'h7FF, 5'h00, 0, 0, 6'd63, 5'd11, 16'h7FFF, 0, 0};
        tr_exp  = NUM_W'(644);
`endif
        tbl[2]  = '{11'h401, 5'h00, 0, 0, 6'd30, 5'd3,  16'h3C00, 0, 0};
        tbl[3]  = '{11'h400, 5'h00, 1, 0, 6'd30, 5'd4,  16'h3E00, 0, 0};
        tbl[4]  = '{11'h400, 5'h10, 0, 0, 6'd20, 5'd5,  16'h0800, 0, 0};
        tbl[6]  = '{11'h400, 5'h00, 0, 0, 6'd1,  5'd7,  16'h0200, 0, 0};
        tbl[7]  = '{11'h000, 5'h00, 0, 1, 6'd40, 5'd8,  16'h8000, 0, 0};
        tbl[8]  = '{11'h400, 5'h01, 0, 0, 6'd63, 5'd9,  16'h7FFF, 1, 0};
        tbl[9]  = '{11'h400, 5'h1D, 0, 1, 6'd2,  5'd10, 16'h8000, 0, 1};
        tbl[11] = '{11'h400, 5'h00, 0, 1, 6'd30, 5'd12, 16'hBC00, 0, 0};
        tbl[12] = '{11'h400, 5'h1F, 0, 0, 6'd1,  5'd13, 16'h0000, 0, 1};
        tbl[13] = '{11'h400, 5'h0F, 0, 0, 6'd48, 5'd14, 16'h7E00, 0, 0};

        // Reset state
        rst_n = 1'b0; i_clr = 1'b0; i_inhibit = 1'b0;
        drive(tbl[0], 1'b0);
        repeat (3) tick();
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_result", 64'(o_result), 64'(0));
        chk("rst_flags", 64'({o_ovf, o_unf}), 64'(0));
        chk("rst_cnt", 64'(o_out_cnt), 64'(0));
        chk("tr_num", 64'(o_transistor_num), 64'(tr_exp));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) run_vec(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Sticky overflow survives clean results, then clears.
        clean = tbl[0];
        run_vec(tbl[8], 1'b1, "stk_ovf");
        for (int i = 0; i < 3; i++) begin
            run_vec(clean, 1'b0, $sformatf("stk_clean%0d", i));
            chk($sformatf("stk_hold%0d", i), 64'(o_ovf), 64'(1));
        end
        chk("stk_cnt", 64'(o_out_cnt), 64'(4));
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("stk_clr_ovf", 64'(o_ovf), 64'(0));
        chk("stk_clr_cnt", 64'(o_out_cnt), 64'(0));

        // Build count up, then clear on the same edge as an overflow load.
        run_vec(clean, 1'b0, "pre1");
        run_vec(clean, 1'b0, "pre2");
        chk("pre_cnt", 64'(o_out_cnt), 64'(2));
        drive(tbl[8], 1'b1);
        tick();
        i_valid = 1'b0;
        i_clr   = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("setwin_ovf", 64'(o_ovf), 64'(1));
        chk("clrinc_cnt", 64'(o_out_cnt), 64'(1));
        chk("setwin_res", 64'(o_result), 64'(16'h7FFF));

        // Stream with a 3-cycle stall mid-flight.
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        for (int k = 0; k < 6; k++)
            sv[k] = '{11'h400, 5'h00, 0, 0, 6'(10 + k), 5'(20 + k), 16'((10 + k) << 9), 0, 0};
        idx = 0; outn = 0;
        prev_res = o_result; prev_vld = o_valid; prev_cnt = o_out_cnt;
        for (int cyc = 0; cyc < 14; cyc++) begin
            inh = (cyc >= 3 && cyc < 6);
            i_inhibit = inh;
            if (idx < 6) drive(sv[idx], 1'b1);
            else         i_valid = 1'b0;
            tick();
            if (!inh && idx < 6) idx++;
            if (inh) begin
                chk($sformatf("stall_frz%0d", cyc), 64'({o_valid, o_result, o_out_cnt}),
                    64'({prev_vld, prev_res, prev_cnt}));
            end else if (o_valid) begin
                if (outn < 6) begin
                    chk($sformatf("stream_res%0d", outn), 64'(o_result), 64'(sv[outn].res));
                    chk($sformatf("stream_q%0d", outn), 64'(o_Q_frac), 64'(sv[outn].q));
                end
                outn++;
            end
            prev_res = o_result; prev_vld = o_valid; prev_cnt = o_out_cnt;
        end
        i_inhibit = 1'b0;
        chk("stream_outn", 64'(outn), 64'(6));
        chk("stream_cnt", 64'(o_out_cnt), 64'(6));

        // Clear while stalled.
        i_inhibit = 1'b1;
        i_clr     = 1'b1;
        tick();
        i_clr     = 1'b0;
        i_inhibit = 1'b0;
        chk("clr_inh_cnt", 64'(o_out_cnt), 64'(0));

        // Async reset mid-stream.
        drive(tbl[8], 1'b1);
        tick();
        drive(clean, 1'b1);
        tick();
        chk("pre_rst_vld", 64'(o_valid), 64'(1));
        #2;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("arst_outs", 64'({o_valid, o_result, o_Q_frac, o_ovf, o_unf, o_out_cnt}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_vld", 64'(o_valid), 64'(0));
        end
        chk("post_rst_cnt", 64'(o_out_cnt), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
